// File: rtl/sys_status_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : sys_status_monitor
//  Description : Heartbeat LED plus per-channel valid/ready handshake monitor
//                with saturating transfer/stall counters, sticky stall flags,
//                PIO-controlled snapshot/clear and per-channel readback.
//  Revision    : 1.0  initial release
// ============================================================================
module sys_status_monitor #(
    parameter int CLOCK_FREQ  = 50_000_000,
    parameter int BLINK_HZ    = 1,
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 32,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] ch_valid,
    input  logic [CHANNELS-1:0] ch_ready,
    input  logic [31:0]         ctrl_pio,
    output logic                blinking_led,
    output logic [31:0]         status_pio,
    output logic [31:0]         xfer_pio,
    output logic [31:0]         stall_pio
);

    localparam int c_HALF = CLOCK_FREQ / (2 * BLINK_HZ);
    localparam int c_BW   = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam int c_RW   = $clog2(STALL_LIMIT + 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(c_HALF - 1);
    localparam logic [c_RW-1:0] c_RUN_MAX    = c_RW'(STALL_LIMIT);

    logic [c_BW-1:0]      r_blink_cnt;
    logic                 r_led;
    logic [CHANNELS-1:0]  r_valid_q;
    logic [CHANNELS-1:0]  r_ready_q;
    logic [1:0]           r_ctrl_q;
    logic [1:0]           r_ctrl_d;
    logic [CNT_WIDTH-1:0] r_xfer         [CHANNELS];
    logic [CNT_WIDTH-1:0] r_stall        [CHANNELS];
    logic [c_RW-1:0]      r_run          [CHANNELS];
    logic [CNT_WIDTH-1:0] r_shadow_xfer  [CHANNELS];
    logic [CNT_WIDTH-1:0] r_shadow_stall [CHANNELS];
    logic [CHANNELS-1:0]  r_flag;
    logic [31:0]          r_status;
    logic [31:0]          r_xfer_pio;
    logic [31:0]          r_stall_pio;

    logic [CNT_WIDTH-1:0] w_xfer_nxt  [CHANNELS];
    logic [CNT_WIDTH-1:0] w_stall_nxt [CHANNELS];
    logic [c_RW-1:0]      w_run_nxt   [CHANNELS];
    logic [CHANNELS-1:0]  w_flag_nxt;
    logic                 w_snap;
    logic                 w_clr;
    logic [31:0]          w_xfer_sel;
    logic [31:0]          w_stall_sel;
    logic [31:0]          w_status;
    logic                 w_unused;

    // Only the snapshot/clear bits and the channel select carry meaning.
    assign w_unused = ^{ctrl_pio[31:12], ctrl_pio[7:2]};

    // Heartbeat: toggle the LED each time the half-period counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_led       <= 1'b0;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_led       <= ~r_led;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BW'(1);
        end
    end

    // Register handshake inputs and control levels (two deep for edge detect).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= '0;
            r_ready_q <= '0;
            r_ctrl_q  <= '0;
            r_ctrl_d  <= '0;
        end else begin
            r_valid_q <= ch_valid;
            r_ready_q <= ch_ready;
            r_ctrl_q  <= ctrl_pio[1:0];
            r_ctrl_d  <= r_ctrl_q;
        end
    end

    assign w_snap = r_ctrl_q[0] & ~r_ctrl_d[0];
    assign w_clr  = r_ctrl_q[1] & ~r_ctrl_d[1];

    // Next counter values ignoring clear; snapshot captures exactly these.
    always_comb begin
        w_flag_nxt = r_flag;
        for (int i = 0; i < CHANNELS; i++) begin
            w_xfer_nxt[i]  = r_xfer[i];
            w_stall_nxt[i] = r_stall[i];
            w_run_nxt[i]   = r_run[i];
            if (r_valid_q[i] && r_ready_q[i]) begin
                if (r_xfer[i] != '1) w_xfer_nxt[i] = r_xfer[i] + CNT_WIDTH'(1);
                w_run_nxt[i] = '0;
            end else if (r_valid_q[i]) begin
                if (r_stall[i] != '1) w_stall_nxt[i] = r_stall[i] + CNT_WIDTH'(1);
                if (r_run[i] != c_RUN_MAX) w_run_nxt[i] = r_run[i] + c_RW'(1);
            end else begin
                w_run_nxt[i] = '0;
            end
            if (w_run_nxt[i] == c_RUN_MAX) w_flag_nxt[i] = 1'b1;
        end
    end

    // Live counters, sticky flags and shadows; clear wins over any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_xfer[i]         <= '0;
                r_stall[i]        <= '0;
                r_run[i]          <= '0;
                r_shadow_xfer[i]  <= '0;
                r_shadow_stall[i] <= '0;
            end
        end else begin
            r_flag <= w_clr ? '0 : w_flag_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                r_xfer[i]  <= w_clr ? '0 : w_xfer_nxt[i];
                r_stall[i] <= w_clr ? '0 : w_stall_nxt[i];
                r_run[i]   <= w_clr ? '0 : w_run_nxt[i];
                if (w_snap) begin
                    r_shadow_xfer[i]  <= w_xfer_nxt[i];
                    r_shadow_stall[i] <= w_stall_nxt[i];
                end
            end
        end
    end

    // Readback mux: out-of-range selects fall through to zero.
    always_comb begin
        w_xfer_sel  = '0;
        w_stall_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ctrl_pio[11:8] == 4'(i)) begin
                w_xfer_sel[CNT_WIDTH-1:0]  = r_shadow_xfer[i];
                w_stall_sel[CNT_WIDTH-1:0] = r_shadow_stall[i];
            end
        end
    end

    // Pack status word with zero padding above the used bits.
    always_comb begin
        w_status                 = '0;
        w_status[3*CHANNELS-1:0] = {r_flag, r_valid_q, r_ready_q};
    end

    // Registered PIO outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status    <= '0;
            r_xfer_pio  <= '0;
            r_stall_pio <= '0;
        end else begin
            r_status    <= w_status;
            r_xfer_pio  <= w_xfer_sel;
            r_stall_pio <= w_stall_sel;
        end
    end

    assign blinking_led = r_led;
    assign status_pio   = r_status;
    assign xfer_pio     = r_xfer_pio;
    assign stall_pio    = r_stall_pio;

endmodule
`default_nettype wire

// File: tb/tb_sys_status_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_status_monitor
//  Description : Scoreboard bench for sys_status_monitor (HALF=4, 4 channels,
//                8-bit counters, stall limit 16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sys_status_monitor;

    localparam int CH  = 4;
    localparam int LIM = 16;
    localparam int MAXC = 255;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ch_valid = '0;
    logic [3:0]  ch_ready = '0;
    logic        snap = 1'b0;
    logic        clr  = 1'b0;
    logic [3:0]  sel  = '0;
    logic [31:0] ctrl_pio;
    logic        blinking_led;
    logic [31:0] status_pio;
    logic [31:0] xfer_pio;
    logic [31:0] stall_pio;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    int   m_xfer[CH], m_stall[CH], m_run[CH], m_sx[CH], m_ss[CH];
    logic [3:0] m_flag;

    assign ctrl_pio = {20'd0, sel, 6'd0, clr, snap};

    sys_status_monitor #(
        .CLOCK_FREQ (8),
        .BLINK_HZ   (1),
        .CHANNELS   (CH),
        .CNT_WIDTH  (8),
        .STALL_LIMIT(LIM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_valid    (ch_valid),
        .ch_ready    (ch_ready),
        .ctrl_pio    (ctrl_pio),
        .blinking_led(blinking_led),
        .status_pio  (status_pio),
        .xfer_pio    (xfer_pio),
        .stall_pio   (stall_pio)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- model and stimulus helpers ----------------
    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_xfer[i] = 0; m_stall[i] = 0; m_run[i] = 0; m_sx[i] = 0; m_ss[i] = 0;
        end
        m_flag = '0;
    endtask

    function automatic logic [31:0] status_exp(logic [3:0] v, logic [3:0] r);
        return {20'd0, m_flag, v, r};
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold a handshake pattern for n cycles, advancing the model once per cycle.
    task automatic drive(logic [3:0] v, logic [3:0] r, int n);
        ch_valid = v;
        ch_ready = r;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) begin
                if (v[i] && r[i]) begin
                    if (m_xfer[i] < MAXC) m_xfer[i]++;
                    m_run[i] = 0;
                end else if (v[i]) begin
                    if (m_stall[i] < MAXC) m_stall[i]++;
                    if (m_run[i] < LIM) m_run[i]++;
                    if (m_run[i] == LIM) m_flag[i] = 1'b1;
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic idle(int n);
        ch_valid = '0;
        ch_ready = '0;
        for (int i = 0; i < CH; i++) m_run[i] = 0;
        step(n);
    endtask

    // bits[0] = snapshot, bits[1] = clear; one rising edge each.
    task automatic pulse(logic [1:0] bits);
        snap = bits[0];
        clr  = bits[1];
        step(4);
        if (bits[0]) for (int i = 0; i < CH; i++) begin m_sx[i] = m_xfer[i]; m_ss[i] = m_stall[i]; end
        if (bits[1]) begin
            for (int i = 0; i < CH; i++) begin m_xfer[i] = 0; m_stall[i] = 0; m_run[i] = 0; end
            m_flag = '0;
        end
        snap = 1'b0;
        clr  = 1'b0;
        step(2);
    endtask

    task automatic select(int s, string name);
        exp_t x, y;
        sel    = 4'(s);
        x.name = {name, " xfer_pio"};
        y.name = {name, " stall_pio"};
        x.val  = (s < CH) ? 32'(m_sx[s]) : 32'd0;
        y.val  = (s < CH) ? 32'(m_ss[s]) : 32'd0;
        sb.push_back(x);
        sb.push_back(y);
        step(2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        exp_t x;
        model_reset();
        step(2);
        n_vec++;
        if (blinking_led !== 1'b0) begin n_err++; $display("FAIL reset led: got %0b want 0", blinking_led); end
        n_vec++;
        if (status_pio !== 32'd0) begin n_err++; $display("FAIL reset status: got %08h want 0", status_pio); end
        n_vec++;
        if (xfer_pio !== 32'd0) begin n_err++; $display("FAIL reset xfer: got %0d want 0", xfer_pio); end
        n_vec++;
        if (stall_pio !== 32'd0) begin n_err++; $display("FAIL reset stall: got %0d want 0", stall_pio); end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            x.name = $sformatf("led cycle %0d", k);
            x.val  = 32'((k / 4) % 2);
            sb.push_back(x);
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if ({31'd0, blinking_led} !== e.val) begin
                n_err++; $display("FAIL %s: got %0b want %0d", e.name, blinking_led, e.val);
            end
        end
    endtask

    task automatic test_counting();
        exp_t x;
        drive(4'b0011, 4'b0001, 2);
        x.name = "status live handshake"; x.val = status_exp(4'b0011, 4'b0001); sb.push_back(x);
        e = sb.pop_front(); n_vec++;
        if (status_pio !== e.val) begin n_err++; $display("FAIL %s: got %08h want %08h", e.name, status_pio, e.val); end
        drive(4'b0011, 4'b0001, 3);
        drive(4'b0001, 4'b0001, 5);
        idle(3);
        pulse(2'b01);
        for (int s = 0; s < 2; s++) begin
            select(s, $sformatf("count ch%0d", s));
            e = sb.pop_front(); n_vec++;
            if (xfer_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, xfer_pio, e.val); end
            e = sb.pop_front(); n_vec++;
            if (stall_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, stall_pio, e.val); end
        end
    endtask

    task automatic test_sticky();
        exp_t x;
        pulse(2'b10);
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: drive(4'b0100, 4'b0000, LIM - 1);
                1: drive(4'b0100, 4'b0000, LIM);
                2: drive(4'b0100, 4'b0100, 3);
                default: ;
            endcase
            idle(3);
            if (ph == 3) pulse(2'b10);
            x.name = $sformatf("sticky phase %0d status", ph);
            x.val  = status_exp(4'b0000, 4'b0000);
            sb.push_back(x);
            e = sb.pop_front(); n_vec++;
            if (status_pio !== e.val) begin n_err++; $display("FAIL %s: got %08h want %08h", e.name, status_pio, e.val); end
        end
    endtask

    task automatic test_snap_clear();
        pulse(2'b10);
        drive(4'b0001, 4'b0001, 7);
        idle(3);
        pulse(2'b11);
        select(0, "snap+clear ch0");
        e = sb.pop_front(); n_vec++;
        if (xfer_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, xfer_pio, e.val); end
        e = sb.pop_front(); n_vec++;
        if (stall_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, stall_pio, e.val); end
        pulse(2'b01);
        select(1, "after clear ch1");
        select(0, "after clear ch0");
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                e = sb.pop_front(); e = sb.pop_front();
                continue;
            end
            e = sb.pop_front(); n_vec++;
            if (xfer_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, xfer_pio, e.val); end
            e = sb.pop_front(); n_vec++;
            if (stall_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, stall_pio, e.val); end
        end
    endtask

    task automatic test_saturation();
        pulse(2'b10);
        drive(4'b1000, 4'b1000, 300);
        idle(3);
        pulse(2'b01);
        select(3, "saturate ch3");
        e = sb.pop_front(); n_vec++;
        if (xfer_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, xfer_pio, e.val); end
        e = sb.pop_front(); n_vec++;
        if (stall_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, stall_pio, e.val); end
        // Held snapshot level: only the rising edge captures.
        pulse(2'b10);
        snap = 1'b1;
        step(4);
        for (int i = 0; i < CH; i++) begin m_sx[i] = m_xfer[i]; m_ss[i] = m_stall[i]; end
        drive(4'b0001, 4'b0001, 5);
        idle(3);
        step(8);
        select(0, "held snapshot ch0");
        e = sb.pop_front(); n_vec++;
        if (xfer_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, xfer_pio, e.val); end
        e = sb.pop_front(); n_vec++;
        if (stall_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, stall_pio, e.val); end
        snap = 1'b0;
        step(2);
        pulse(2'b01);
        select(0, "fresh snapshot ch0");
        e = sb.pop_front(); n_vec++;
        if (xfer_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, xfer_pio, e.val); end
        e = sb.pop_front(); n_vec++;
        if (stall_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, stall_pio, e.val); end
    endtask

    task automatic test_sel_range_and_reset();
        exp_t x;
        select(15, "ch_sel 15");
        e = sb.pop_front(); n_vec++;
        if (xfer_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, xfer_pio, e.val); end
        e = sb.pop_front(); n_vec++;
        if (stall_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, stall_pio, e.val); end
        select(0, "pre-reset ch0");
        e = sb.pop_front(); n_vec++;
        if (xfer_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, xfer_pio, e.val); end
        e = sb.pop_front(); n_vec++;
        if (stall_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, stall_pio, e.val); end
        drive(4'b0001, 4'b0001, 4);
        x.name = "pre-reset status"; x.val = status_exp(4'b0001, 4'b0001); sb.push_back(x);
        e = sb.pop_front(); n_vec++;
        if (status_pio !== e.val) begin n_err++; $display("FAIL %s: got %08h want %08h", e.name, status_pio, e.val); end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (blinking_led !== 1'b0) begin n_err++; $display("FAIL midreset led: got %0b want 0", blinking_led); end
        n_vec++;
        if (status_pio !== 32'd0) begin n_err++; $display("FAIL midreset status: got %08h want 0", status_pio); end
        n_vec++;
        if (xfer_pio !== 32'd0) begin n_err++; $display("FAIL midreset xfer: got %0d want 0", xfer_pio); end
        n_vec++;
        if (stall_pio !== 32'd0) begin n_err++; $display("FAIL midreset stall: got %0d want 0", stall_pio); end
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        select(0, "post-reset ch0");
        e = sb.pop_front(); n_vec++;
        if (xfer_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, xfer_pio, e.val); end
        e = sb.pop_front(); n_vec++;
        if (stall_pio !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, stall_pio, e.val); end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_sticky();
        test_snap_clear();
        test_saturation();
        test_sel_range_and_reset();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
